unified_memory_pipelined: RTL
=============================

Name: unified_memory_pipelined

Overview:
Parametrised successor to the flat unified instruction/data memory. It adds a valid/ready request and response handshake on both ports, a configurable read latency of 1..4 cycles, and a 32- or 64-bit data path. It flags misaligned and out-of-range accesses instead of silently returning zero. It sits between the fetch stage / LSU and the shared byte-addressed program+data RAM.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data port width; 32 or 64 only (instruction port is always 32)
MEM_SIZE, 2097152, bytes; must be a multiple of DATA_WIDTH/8
READ_LATENCY, 1, cycles from request accept to response valid; 1..4
RESET_FILL, 32'h00000013, 32-bit word pattern used to pre-fill the array at time zero (NOP)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_valid  in  1  fetch request
i_req_ready  out  1  fetch request accepted when valid&ready
i_req_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
i_rsp_valid  out  1  fetch response valid
i_rsp_ready  in  1  fetch consumer ready
i_rsp_data  out  32  instruction word
i_rsp_err  out  1  out-of-range fetch
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted when valid&ready
d_req_addr  in  ADDR_WIDTH  byte address
d_req_we  in  1  1 = store, 0 = load
d_req_wdata  in  DATA_WIDTH  store data, lane-aligned to the word at addr & ~(DATA_WIDTH/8-1)
d_req_be  in  DATA_WIDTH/8  store byte-lane enables for that aligned word
d_req_load_type  in  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
d_rsp_valid  out  1  data response valid (loads and stores both respond)
d_rsp_ready  in  1  data consumer ready
d_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
d_rsp_err  out  1  misaligned, out-of-range, or illegal load type

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all response valids 0, errs 0, rdata/data 0.
  - Array contents are NOT altered by reset; pre-fill happens only at time zero, plus the optional hex load under INSTR_HEX_FILE.
  - Reset mid-operation flushes all in-flight responses. A store accepted in the cycle rst is high is not committed.
- Each port owns an independent READ_LATENCY-stage pipeline, each stage holding {valid, payload}.
  - The array is read at the accept edge.
  - Stages 2..READ_LATENCY are delay registers.
- Stall: a port's pipeline advances only when its last stage is empty or rsp_ready=1.
  - req_ready = !rst && (last stage empty || rsp_ready).
  - Response outputs must hold stable while valid && !ready.
- Accept-to-valid latency is exactly READ_LATENCY cycles when unstalled. Throughput is one request per cycle per port.
- Loads:
  - Data comes from bytes addr..addr+size-1, little-endian; sign/zero extension per load_type.
  - Natural alignment is required: LH needs addr[0]=0, LW needs addr[1:0]=0, LD needs addr[2:0]=0.
  - Violation -> err=1, rdata=0.
  - LD, and LWU at DATA_WIDTH=32, are illegal -> err=1.
- Stores:
  - Committed to the array on the accept edge.
  - Lane k written iff be[k] and the target byte address is < MEM_SIZE.
  - If any enabled lane is out of range: err=1 and no lanes are written (all-or-nothing).
  - Response is valid with rdata=0.
  - be=0 is a legal no-op with err=0.
- Range: an access is out of range if addr+size > MEM_SIZE, computed in ADDR_WIDTH+1 bits so there is no wrap-around.
  - Out-of-range fetch -> i_rsp_data=RESET_FILL, err=1.
- Same-cycle fetch and store to an overlapping word: the fetch returns pre-store data unless the optional feature is enabled.
  - Fetches and loads accepted after the store's accept edge see new data.

Optional Feature:
Macro UNIFIED_MEM_WRITE_BYPASS_EN.
- Defined: a fetch accepted in the same cycle as a store to the same aligned 32-bit word returns the merged data, with store lanes applied per be, i.e. write-first.
- Undefined: read-first, as stated in Behaviour.
- The data port is unaffected either way.

Test Plan:
- After reset, fetch 0x0 with no hex file, READ_LATENCY=1 -> i_rsp_valid exactly 1 cycle later, data=0x00000013, err=0.
- Store addr 0x100 wdata 0x80FF1234 be=4'b1111, then LB@0x103 / LBU@0x103 / LH@0x102 / LHU@0x100 -> 0xFFFFFF80 / 0x00000080 / 0xFFFF80FF / 0x00001234, all err=0.
- LW@0x102 -> err=1, rdata=0. SW with be=4'b1111 at addr MEM_SIZE-2 -> err=1 and bytes MEM_SIZE-2..MEM_SIZE-1 unchanged (confirmed by read-back).
- READ_LATENCY=3, fetch requests back-to-back at 0x0,0x4,0x8 with i_rsp_ready low for cycles 4-5 -> i_req_ready drops while stalled, data held stable, three responses in order, none lost or duplicated.
- Same-cycle store 0xDEADBEEF@0x200 and fetch 0x200 (prior 0x00000013) -> fetch returns 0x00000013 without the macro and 0xDEADBEEF with it; a following fetch returns 0xDEADBEEF in both builds.
- Assert rst with two loads in flight -> both d_rsp_valid deasserted the next cycle and no response emitted; a store accepted while rst=1 leaves memory unchanged.

Source files
------------

// File: rtl/unified_memory_pipelined_if.sv
// Fetch and data request/response bundle for unified_memory_pipelined.
// master = fetch stage / LSU side, slave = memory side.
interface unified_memory_pipelined_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    i_req_valid;
    logic                    i_req_ready;
    logic [ADDR_WIDTH-1:0]   i_req_addr;
    logic                    i_rsp_valid;
    logic                    i_rsp_ready;
    logic [31:0]             i_rsp_data;
    logic                    i_rsp_err;

    logic                    d_req_valid;
    logic                    d_req_ready;
    logic [ADDR_WIDTH-1:0]   d_req_addr;
    logic                    d_req_we;
    logic [DATA_WIDTH-1:0]   d_req_wdata;
    logic [DATA_WIDTH/8-1:0] d_req_be;
    logic [2:0]              d_req_load_type;
    logic                    d_rsp_valid;
    logic                    d_rsp_ready;
    logic [DATA_WIDTH-1:0]   d_rsp_rdata;
    logic                    d_rsp_err;

    modport master (
        output i_req_valid, i_req_addr, i_rsp_ready,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_be, d_req_load_type, d_rsp_ready,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_addr, i_rsp_ready,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_be, d_req_load_type, d_rsp_ready,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );
endinterface

// File: rtl/unified_memory_pipelined.sv
// Shared byte-addressed program+data RAM with independent fetch/data pipelines of READ_LATENCY stages.
// Define UNIFIED_MEM_WRITE_BYPASS_EN to make same-cycle fetches see the concurrent store (write-first).
module unified_memory_pipelined #(
    parameter int                ADDR_WIDTH   = 32,
    parameter int                DATA_WIDTH   = 32,
    parameter longint unsigned   MEM_SIZE     = 2097152,
    parameter int                READ_LATENCY = 1,
    parameter logic [31:0]       RESET_FILL   = 32'h00000013
) (
    input logic                        clk,
    input logic                        rst,
    unified_memory_pipelined_if.slave  bus
);
    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int NSUB      = DATA_WIDTH / 32;
    localparam int MEM_WORDS = int'(MEM_SIZE / 4);
    localparam int WI        = $clog2(MEM_WORDS);
    localparam int RL        = READ_LATENCY;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

    // Pre-filled once at time zero; reset never touches the array.
    logic [31:0] mem [MEM_WORDS] = '{default: RESET_FILL};

    // ---------------- fetch port ----------------
    logic [ADDR_WIDTH-1:0] i_addr_al;
    logic [WI-1:0]         i_widx;
    logic                  i_oor, i_adv, i_acc;
    logic [31:0]           i_word;
    logic [RL-1:0]         i_vld_pipe, i_err_pipe;
    logic [31:0]           i_dat_pipe [RL];

    // ---------------- data port ----------------
    logic [2:0]            lt;
    logic [3:0]            d_size;
    logic                  d_oor, d_mis, d_ill, s_oor, d_err, d_adv, d_acc, s_commit;
    logic [WI-1:0]         d_widx, s_wbase;
    logic [31:0]           w0, w1;
    logic [7:0]            b8;
    logic [15:0]           h16;
    logic [DATA_WIDTH-1:0] ld, d_rdata;
    logic [RL-1:0]         d_vld_pipe, d_err_pipe;
    logic [DATA_WIDTH-1:0] d_dat_pipe [RL];

    assign i_addr_al       = bus.i_req_addr & ~ADDR_WIDTH'(3);
    assign i_oor           = ({1'b0, i_addr_al} + (ADDR_WIDTH+1)'(4)) > LIMIT;
    assign i_widx          = i_oor ? '0 : i_addr_al[WI+1:2];
    assign i_adv           = !i_vld_pipe[RL-1] || bus.i_rsp_ready;
    assign bus.i_req_ready = !rst && i_adv;
    assign i_acc           = bus.i_req_valid && bus.i_req_ready;

    always_comb begin
        i_word = mem[i_widx];
        if (i_oor) i_word = RESET_FILL;
`ifdef UNIFIED_MEM_WRITE_BYPASS_EN
        for (int j = 0; j < NSUB; j++)
            if (!i_oor && s_commit && i_widx == s_wbase + WI'(j))
                for (int b = 0; b < 4; b++)
                    if (bus.d_req_be[4*j+b]) i_word[8*b +: 8] = bus.d_req_wdata[32*j+8*b +: 8];
`endif
    end

    // Whole pipeline freezes while the head response waits on rsp_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_vld_pipe <= '0;
            i_err_pipe <= '0;
            for (int s = 0; s < RL; s++) i_dat_pipe[s] <= '0;
        end else if (i_adv) begin
            i_vld_pipe[0] <= i_acc;
            i_err_pipe[0] <= i_acc && i_oor;
            i_dat_pipe[0] <= i_acc ? i_word : '0;
            for (int s = 1; s < RL; s++) begin
                i_vld_pipe[s] <= i_vld_pipe[s-1];
                i_err_pipe[s] <= i_err_pipe[s-1];
                i_dat_pipe[s] <= i_dat_pipe[s-1];
            end
        end
    end

    assign bus.i_rsp_valid = i_vld_pipe[RL-1];
    assign bus.i_rsp_err   = i_err_pipe[RL-1];
    assign bus.i_rsp_data  = i_dat_pipe[RL-1];

    // Load size from load_type[1:0]: 1, 2, 4 or 8 bytes.
    assign lt     = bus.d_req_load_type;
    assign d_size = 4'd1 << lt[1:0];
    assign d_oor  = ({1'b0, bus.d_req_addr} + (ADDR_WIDTH+1)'(d_size)) > LIMIT;
    assign d_mis  = (bus.d_req_addr[2:0] & (d_size[2:0] - 3'd1)) != 3'd0;
    assign d_ill  = (lt == 3'b111) || (DATA_WIDTH == 32 && (lt == 3'b011 || lt == 3'b110));
    assign s_oor  = (bus.d_req_be != '0) &&
                    (({1'b0, bus.d_req_addr} + (ADDR_WIDTH+1)'(NBYTES)) > LIMIT);
    assign d_err  = bus.d_req_we ? s_oor : (d_oor || d_mis || d_ill);

    assign d_adv           = !d_vld_pipe[RL-1] || bus.d_rsp_ready;
    assign bus.d_req_ready = !rst && d_adv;
    assign d_acc           = bus.d_req_valid && bus.d_req_ready;
    assign s_commit        = d_acc && bus.d_req_we && !s_oor;

    assign d_widx  = d_oor ? '0 : bus.d_req_addr[WI+1:2];
    assign s_wbase = bus.d_req_addr[WI+1:2] & ~WI'(NSUB-1);

    always_comb begin
        w0  = mem[d_widx];
        w1  = mem[d_widx | WI'(1)];
        b8  = w0[{bus.d_req_addr[1:0], 3'b000} +: 8];
        h16 = w0[{bus.d_req_addr[1], 4'b0000} +: 16];
        case (lt)
            3'b000:  ld = DATA_WIDTH'(signed'(b8));
            3'b001:  ld = DATA_WIDTH'(signed'(h16));
            3'b010:  ld = DATA_WIDTH'(signed'(w0));
            3'b011:  ld = DATA_WIDTH'({w1, w0});
            3'b100:  ld = DATA_WIDTH'(b8);
            3'b101:  ld = DATA_WIDTH'(h16);
            3'b110:  ld = DATA_WIDTH'(w0);
            default: ld = '0;
        endcase
        d_rdata = (bus.d_req_we || d_err) ? '0 : ld;
    end

    // Stores land at the accept edge, all lanes or none.
    always_ff @(posedge clk) begin
        if (s_commit)
            for (int j = 0; j < NSUB; j++)
                for (int b = 0; b < 4; b++)
                    if (bus.d_req_be[4*j+b])
                        mem[s_wbase + WI'(j)][8*b +: 8] <= bus.d_req_wdata[32*j+8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_vld_pipe <= '0;
            d_err_pipe <= '0;
            for (int s = 0; s < RL; s++) d_dat_pipe[s] <= '0;
        end else if (d_adv) begin
            d_vld_pipe[0] <= d_acc;
            d_err_pipe[0] <= d_acc && d_err;
            d_dat_pipe[0] <= d_acc ? d_rdata : '0;
            for (int s = 1; s < RL; s++) begin
                d_vld_pipe[s] <= d_vld_pipe[s-1];
                d_err_pipe[s] <= d_err_pipe[s-1];
                d_dat_pipe[s] <= d_dat_pipe[s-1];
            end
        end
    end

    assign bus.d_rsp_valid = d_vld_pipe[RL-1];
    assign bus.d_rsp_err   = d_err_pipe[RL-1];
    assign bus.d_rsp_rdata = d_dat_pipe[RL-1];
endmodule
